// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the GPIO access arbiter.
// Lock feature: GPIO_ARB_LOCK_EN.
package gpio_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SAMPLE,
        CAPTURE,
        RESP
    } arb_state_e;

    localparam int GPIO_GW = 4;
    localparam int GPIO_DW = 32;
    localparam logic [GPIO_GW-1:0] WBYTE_ALL = 4'hF;

endpackage

// File: rtl/gpio_access_arbiter_if.sv
// Requester-side bundle of the GPIO access arbiter.
// req_lock exists only with GPIO_ARB_LOCK_EN.
interface gpio_access_arbiter_if #(
    parameter int NREQ = 2
);
    import gpio_arb_pkg::*;

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         req_write;
    logic [GPIO_GW*NREQ-1:0] req_group;
    logic [GPIO_DW*NREQ-1:0] req_mask;
    logic [GPIO_DW*NREQ-1:0] req_ena;
    logic [GPIO_DW*NREQ-1:0] req_dat;
    logic [NREQ-1:0]         rsp_valid;
    logic [GPIO_DW-1:0]      rsp_rdata;
`ifdef GPIO_ARB_LOCK_EN
    logic [NREQ-1:0]         req_lock;

    modport master (
        output req_valid, req_write, req_group,
        output req_mask, req_ena, req_dat, req_lock,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_write, req_group,
        input  req_mask, req_ena, req_dat, req_lock,
        output req_ready, rsp_valid, rsp_rdata
    );
`else
    modport master (
        output req_valid, req_write, req_group,
        output req_mask, req_ena, req_dat,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_write, req_group,
        input  req_mask, req_ena, req_dat,
        output req_ready, rsp_valid, rsp_rdata
    );
`endif

endinterface

// File: rtl/gpio_access_arbiter_rr_arbiter.sv
// Round-robin grant: first valid requester at or after the pointer.
// The pointer moves past the winner on take unless hold is set.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic            clk,
    input  logic            RSTn,
    input  logic [NREQ-1:0] req,
    input  logic            take,
    input  logic            hold,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            any
);

    logic [PW-1:0] ptr_q;
    int            j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr_q) + i) % NREQ;
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            ptr_q <= '0;
        end else if (take && !hold) begin
            if (int'(gnt_idx) == NREQ - 1)
                ptr_q <= '0;
            else
                ptr_q <= gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_access_arbiter.sv
// Shares the GPIO block between NREQ requesters; keeps per-group shadows.
// GPIO_ARB_LOCK_EN adds req_lock to keep a grant across accesses.
module gpio_access_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int NGROUP = 4
) (
    input  logic                 clk,
    input  logic                 RSTn,
    gpio_access_arbiter_if.slave bus,
    output logic [GPIO_GW-1:0]   gpio_group,
    output logic [GPIO_GW-1:0]   gpio_wbyte,
    output logic [GPIO_DW-1:0]   gpio_ena,
    output logic [GPIO_DW-1:0]   gpio_dat,
    input  logic [GPIO_DW-1:0]   gpio_idat
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e         state_q, state_d;
    logic [NREQ-1:0]    req_eff, gnt, own_q;
    logic [PW-1:0]      gnt_idx;
    logic               any, take, hold;
    logic               wr_q, in_range;
    logic [GPIO_GW-1:0] grp_q, grp_d;
    logic [GPIO_DW-1:0] mask_q, ena_q, dat_q;
    logic [GPIO_DW-1:0] ena_sel, dat_sel;
    logic [GPIO_DW-1:0] sh_ena_q [NGROUP];
    logic [GPIO_DW-1:0] sh_dat_q [NGROUP];
    logic [GPIO_DW-1:0] sh_ena_d [NGROUP];
    logic [GPIO_DW-1:0] sh_dat_d [NGROUP];

`ifdef GPIO_ARB_LOCK_EN
    logic lock_q;

    assign req_eff = lock_q ? (bus.req_valid & own_q) : bus.req_valid;
    assign hold    = lock_q;

    // Lock drops once the owner idles without both valid and lock.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)
            lock_q <= 1'b0;
        else if (state_q == RESP)
            lock_q <= |(bus.req_lock & own_q);
        else if (state_q == IDLE &&
                 !(|(bus.req_valid & bus.req_lock & own_q)))
            lock_q <= 1'b0;
    end
`else
    assign req_eff = bus.req_valid;
    assign hold    = 1'b0;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .clk     (clk),
        .RSTn    (RSTn),
        .req     (req_eff),
        .take    (take),
        .hold    (hold),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign in_range      = int'(grp_q) < NGROUP;
    assign bus.req_ready = take ? gnt : '0;
    assign bus.rsp_valid = (state_q == RESP) ? own_q : '0;
    assign gpio_wbyte    = (state_q == LATCH && wr_q) ? WBYTE_ALL : '0;

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    take    = 1'b1;
                    state_d = LATCH;
                end
            end
            LATCH:   state_d = wr_q ? RESP : SAMPLE;
            SAMPLE:  state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            own_q  <= '0;
            wr_q   <= 1'b0;
            grp_q  <= '0;
            mask_q <= '0;
            ena_q  <= '0;
            dat_q  <= '0;
        end else if (take) begin
            own_q  <= gnt;
            wr_q   <= bus.req_write[gnt_idx];
            grp_q  <= bus.req_group[int'(gnt_idx)*GPIO_GW +: GPIO_GW];
            mask_q <= bus.req_mask[int'(gnt_idx)*GPIO_DW +: GPIO_DW];
            ena_q  <= bus.req_ena[int'(gnt_idx)*GPIO_DW +: GPIO_DW];
            dat_q  <= bus.req_dat[int'(gnt_idx)*GPIO_DW +: GPIO_DW];
        end
    end

    // Pins always follow the shadow of the selected group, post-merge.
    always_comb begin
        sh_ena_d = sh_ena_q;
        sh_dat_d = sh_dat_q;
        grp_d    = gpio_group;
        if (state_q == LATCH && in_range) begin
            grp_d = grp_q;
            for (int g = 0; g < NGROUP; g++) begin
                if (wr_q && g == int'(grp_q)) begin
                    sh_ena_d[g] = (sh_ena_q[g] & ~mask_q) | (ena_q & mask_q);
                    sh_dat_d[g] = (sh_dat_q[g] & ~mask_q) | (dat_q & mask_q);
                end
            end
        end
        ena_sel = '0;
        dat_sel = '0;
        for (int g = 0; g < NGROUP; g++) begin
            if (g == int'(grp_d)) begin
                ena_sel = sh_ena_d[g];
                dat_sel = sh_dat_d[g];
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int g = 0; g < NGROUP; g++) begin
                sh_ena_q[g] <= '0;
                sh_dat_q[g] <= '0;
            end
            gpio_group <= '0;
            gpio_ena   <= '0;
            gpio_dat   <= '0;
        end else begin
            sh_ena_q   <= sh_ena_d;
            sh_dat_q   <= sh_dat_d;
            gpio_group <= grp_d;
            gpio_ena   <= ena_sel;
            gpio_dat   <= dat_sel;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)
            bus.rsp_rdata <= '0;
        else if (state_q == CAPTURE)
            bus.rsp_rdata <= in_range ? gpio_idat : '0;
        else if (state_q == LATCH && wr_q)
            bus.rsp_rdata <= '0;
    end

endmodule
